// File: rtl/acc_pkg.sv
// Shared encodings for the write-back demux: destination select codes and
// the state type of the holding-register controller.
package acc_pkg;

  localparam logic [1:0] SEL_A = 2'b11;
  localparam logic [1:0] SEL_B = 2'b10;
  localparam logic [1:0] SEL_C = 2'b01;
  localparam logic [1:0] SEL_D = 2'b00;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  // The select code doubles as the bit index into Hold/Wr (bit3=A ... bit0=D).
  function automatic logic [3:0] sel_onehot(input logic [1:0] op);
    sel_onehot = 4'b0001 << op;
  endfunction

endpackage

// File: rtl/demux_dest_reg.sv
// One destination register of the write-back demux: loads on request and
// raises a strobe for exactly the cycle after the load edge.
module demux_dest_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             strobe
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q      <= '0;
      strobe <= 1'b0;
    end else begin
      strobe <= load;
      if (load) begin
        q <= d;
      end
    end
  end

endmodule

// File: rtl/wb_demux4b16.sv
// Write-back demultiplexer: a one-entry holding register steered into one of
// four destination registers, with per-destination backpressure.
module wb_demux4b16
  import acc_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] In,
  input  logic [1:0]       OP,
  input  logic             InValid,
  output logic             InReady,
  input  logic [3:0]       Hold,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] D,
  output logic [3:0]       Wr,
  output logic [7:0]       WrCount
);

  state_t           state;
  logic [1:0]       held_op;
  logic [WIDTH-1:0] held_data;
  logic [7:0]       wr_count;

  logic             drain;
  logic             transfer;
  logic [3:0]       load;
  logic [WIDTH-1:0] dest [4];

  // Only the hold bit of the held destination matters, and only while FULL.
  assign drain    = (state == FULL) && !Hold[held_op];
  assign InReady  = RST_N && ((state == EMPTY) || !Hold[held_op]);
  assign transfer = InValid && InReady;
  assign load     = drain ? sel_onehot(held_op) : 4'b0000;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= EMPTY;
      held_op   <= 2'b00;
      held_data <= '0;
      wr_count  <= 8'd0;
    end else begin
      if (transfer) begin
        held_op   <= OP;
        held_data <= In;
        state     <= FULL;
      end else if (drain) begin
        state <= EMPTY;
      end
      if (drain) begin
        wr_count <= wr_count + 8'd1;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_dest
      demux_dest_reg #(
        .WIDTH(WIDTH)
      ) u_dest (
        .clk   (CLK),
        .rst_n (RST_N),
        .load  (load[gi]),
        .d     (held_data),
        .q     (dest[gi]),
        .strobe(Wr[gi])
      );
    end
  endgenerate

  assign A       = dest[SEL_A];
  assign B       = dest[SEL_B];
  assign C       = dest[SEL_C];
  assign D       = dest[SEL_D];
  assign WrCount = wr_count;

endmodule

// File: tb/tb_wb_demux4b16.sv
// Directed bench for wb_demux4b16: reset, steering, backpressure, reset
// during a stall and counter wrap, each step checked against hand values.
module tb_wb_demux4b16;
  import acc_pkg::*;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [15:0] In;
  logic [1:0]  OP;
  logic        InValid;
  logic        InReady;
  logic [3:0]  Hold;
  logic [15:0] A, B, C, D;
  logic [3:0]  Wr;
  logic [7:0]  WrCount;

  int vectors = 0;
  int fails   = 0;

  wb_demux4b16 #(.WIDTH(16)) dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .In     (In),
    .OP     (OP),
    .InValid(InValid),
    .InReady(InReady),
    .Hold   (Hold),
    .A      (A),
    .B      (B),
    .C      (C),
    .D      (D),
    .Wr     (Wr),
    .WrCount(WrCount)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle on the falling edge where inputs change.
  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  logic [1:0]  ops  [4];
  logic [15:0] vals [4];

  initial begin
    ops  = '{SEL_A, SEL_B, SEL_C, SEL_D};
    vals = '{16'h0008, 16'h0004, 16'h0002, 16'h0001};

    // Reset state
    RST_N = 1'b0; In = '0; OP = 2'b00; InValid = 1'b0; Hold = 4'b0000;
    #1;
    check("rst_A", A, 0); check("rst_B", B, 0); check("rst_C", C, 0); check("rst_D", D, 0);
    check("rst_Wr", Wr, 0); check("rst_WrCount", WrCount, 0); check("rst_InReady", InReady, 0);
    step(); step();
    RST_N = 1'b1;

    // Single write to A, first edge after reset release
    OP = SEL_A; In = 16'h0008; InValid = 1'b1;
    #1 check("single_ready", InReady, 1);
    step();
    InValid = 1'b0;
    check("single_A_early", A, 0); check("single_Wr_early", Wr, 0);
    step();
    check("single_A", A, 16'h0008); check("single_Wr", Wr, 4'b1000);
    check("single_B", B, 0); check("single_C", C, 0); check("single_D", D, 0);
    check("single_cnt", WrCount, 1);
    step();
    check("single_Wr_off", Wr, 0);

    // Back-to-back writes to all four destinations
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        InValid = 1'b1; OP = ops[i]; In = vals[i];
      end else begin
        InValid = 1'b0;
      end
      #1 check("b2b_ready", InReady, 1);
      step();
      if (i > 0) check("b2b_Wr", Wr, 4'b0001 << ops[i-1]);
    end
    check("b2b_A", A, 16'h0008); check("b2b_B", B, 16'h0004);
    check("b2b_C", C, 16'h0002); check("b2b_D", D, 16'h0001);
    check("b2b_cnt", WrCount, 5);

    // Stall on B, then release
    Hold = 4'b0100; OP = SEL_B; In = 16'h1234; InValid = 1'b1;
    #1 check("stall_ready_empty", InReady, 1);
    step();
    InValid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 check("stall_ready", InReady, 0);
      check("stall_B", B, 16'h0004); check("stall_Wr", Wr, 0);
      step();
    end
    Hold = 4'b0000;
    #1 check("release_ready", InReady, 1);
    step();
    check("release_B", B, 16'h1234); check("release_Wr", Wr, 4'b0100);
    check("release_cnt", WrCount, 6);
    step();
    check("release_Wr_once", Wr, 0);

    // Unrelated hold bit has no effect
    Hold = 4'b0100; OP = SEL_C; In = 16'hBEEF; InValid = 1'b1;
    step();
    InValid = 1'b0;
    #1 check("unrel_ready", InReady, 1);
    step();
    check("unrel_C", C, 16'hBEEF); check("unrel_Wr", Wr, 4'b0010);
    check("unrel_B", B, 16'h1234); check("unrel_cnt", WrCount, 7);
    step();

    // Reset asserted mid-cycle while stalled in FULL
    Hold = 4'b1000; OP = SEL_A; In = 16'hAAAA; InValid = 1'b1;
    step();
    InValid = 1'b0;
    #1 check("rstfull_ready", InReady, 0);
    step();
    #2 RST_N = 1'b0;
    #1;
    check("rstfull_A", A, 0); check("rstfull_B", B, 0); check("rstfull_C", C, 0);
    check("rstfull_D", D, 0); check("rstfull_Wr", Wr, 0); check("rstfull_cnt", WrCount, 0);
    check("rstfull_ready_rst", InReady, 0);
    @(negedge CLK);
    RST_N = 1'b1; Hold = 4'b0000;
    step();
    check("postrst_Wr", Wr, 0); check("postrst_A", A, 0); check("postrst_cnt", WrCount, 0);
    step();
    check("postrst_Wr2", Wr, 0);

    // 256 consecutive writes wrap the counter
    for (int i = 0; i < 256; i++) begin
      InValid = 1'b1; OP = i[1:0]; In = i[15:0];
      step();
    end
    InValid = 1'b0;
    check("wrap_cnt255", WrCount, 255);
    step();
    check("wrap_cnt0", WrCount, 0); check("wrap_Wr", Wr, 4'b1000);
    check("wrap_A", A, 16'd255); check("wrap_B", B, 16'd254);
    check("wrap_C", C, 16'd253); check("wrap_D", D, 16'd252);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
